// File: rtl/pipe_ctrl_pkg.sv
// Pipeline control shared types: FSM states, forward selects, drain length.
// Shared by hazard_fwd_unit and pipe_ctrl.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HALT  = 2'd2
  } state_e;

  typedef logic [1:0] fwd_t;
  typedef logic [1:0] cnt_t;

  localparam fwd_t FWD_NONE = 2'b00;
  localparam fwd_t FWD_WB   = 2'b01;
  localparam fwd_t FWD_MEM  = 2'b10;

  localparam cnt_t DRAIN_CYCLES = 2'd3;

  // x0 is hardwired zero, so it never carries a dependency.
  function automatic logic reg_hit(
    input logic [4:0] rd,
    input logic [4:0] rs
  );
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle between the pipeline datapath and pipe_ctrl.
// master = datapath side, slave = controller side.
interface pipe_ctrl_if;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic        use_rs1_d;
  logic        use_rs2_d;
  logic        pause_d;
  logic [4:0]  rs1_e;
  logic [4:0]  rs2_e;
  logic [4:0]  rd_e;
  logic        memtoreg_e;
  logic        writesreg_e;
  logic        redirect_e;
  logic [4:0]  rd_m;
  logic [4:0]  rd_w;
  logic        writesreg_m;
  logic        writesreg_w;
  logic        resume_i;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        flush_e;
  logic [1:0]  fwd_a_e;
  logic [1:0]  fwd_b_e;
  logic        halted;
  logic [31:0] stall_cnt;

  modport master (
    output rs1_d, rs2_d, use_rs1_d, use_rs2_d,
    output pause_d, rs1_e, rs2_e, rd_e,
    output memtoreg_e, writesreg_e, redirect_e,
    output rd_m, rd_w, writesreg_m, writesreg_w,
    output resume_i,
    input  stall_f, stall_d, flush_d, flush_e,
    input  fwd_a_e, fwd_b_e, halted, stall_cnt
  );

  modport slave (
    input  rs1_d, rs2_d, use_rs1_d, use_rs2_d,
    input  pause_d, rs1_e, rs2_e, rd_e,
    input  memtoreg_e, writesreg_e, redirect_e,
    input  rd_m, rd_w, writesreg_m, writesreg_w,
    input  resume_i,
    output stall_f, stall_d, flush_d, flush_e,
    output fwd_a_e, fwd_b_e, halted, stall_cnt
  );
endinterface

// File: rtl/pipe_ctrl_hazard_fwd_unit.sv
// Register compare and operand forward select (purely combinational).
// PIPE_CTRL_FORWARD_EN selects bypassing; otherwise interlock on E/M.
import pipe_ctrl_pkg::*;

module hazard_fwd_unit (
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  input  logic       use_rs1_d,
  input  logic       use_rs2_d,
  input  logic [4:0] rs1_e,
  input  logic [4:0] rs2_e,
  input  logic [4:0] rd_e,
  input  logic       memtoreg_e,
  input  logic       writesreg_e,
  input  logic [4:0] rd_m,
  input  logic       writesreg_m,
  input  logic [4:0] rd_w,
  input  logic       writesreg_w,
  output logic       hazard,
  output fwd_t       fwd_a,
  output fwd_t       fwd_b
);

  logic e1;
  logic e2;
  logic m1;
  logic m2;

  assign e1 = use_rs1_d && reg_hit(rd_e, rs1_d);
  assign e2 = use_rs2_d && reg_hit(rd_e, rs2_d);
  assign m1 = use_rs1_d && reg_hit(rd_m, rs1_d);
  assign m2 = use_rs2_d && reg_hit(rd_m, rs2_d);

`ifdef PIPE_CTRL_FORWARD_EN

  // Only a load in E cannot be bypassed in time.
  always_comb begin
    hazard = memtoreg_e && writesreg_e && (e1 || e2);
  end

  // MEM holds the younger value, so it wins over WB.
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
    if (writesreg_m && reg_hit(rd_m, rs1_e))
      fwd_a = FWD_MEM;
    else if (writesreg_w && reg_hit(rd_w, rs1_e))
      fwd_a = FWD_WB;
    if (writesreg_m && reg_hit(rd_m, rs2_e))
      fwd_b = FWD_MEM;
    else if (writesreg_w && reg_hit(rd_w, rs2_e))
      fwd_b = FWD_WB;
  end

  logic unused_fwd;
  assign unused_fwd = ^{m1, m2};

`else

  // No bypass: wait until the producer reaches W (write-first regfile).
  always_comb begin
    hazard = (writesreg_e && (e1 || e2))
          || (writesreg_m && (m1 || m2));
  end

  // Operands always come from the register file.
  always_comb begin
    fwd_a = FWD_NONE;
    fwd_b = FWD_NONE;
  end

  logic unused_nofwd;
  assign unused_nofwd = ^{rs1_e, rs2_e, memtoreg_e,
                          rd_w, writesreg_w};

`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush/forward control with pause-drain-halt FSM.
// Optional macro PIPE_CTRL_FORWARD_EN enables operand forwarding.
import pipe_ctrl_pkg::*;

module pipe_ctrl (
  input logic      clk,
  input logic      rst_n,
  pipe_ctrl_if.slave bus
);

  state_e      state;
  state_e      state_nxt;
  cnt_t        cnt;
  cnt_t        cnt_nxt;
  logic        halted_q;
  logic [31:0] stall_cnt_q;
  logic        hazard;
  fwd_t        fwd_a;
  fwd_t        fwd_b;
  logic        sf;
  logic        sd;
  logic        fd;
  logic        fe;

  hazard_fwd_unit u_hfu (
    .rs1_d       (bus.rs1_d),
    .rs2_d       (bus.rs2_d),
    .use_rs1_d   (bus.use_rs1_d),
    .use_rs2_d   (bus.use_rs2_d),
    .rs1_e       (bus.rs1_e),
    .rs2_e       (bus.rs2_e),
    .rd_e        (bus.rd_e),
    .memtoreg_e  (bus.memtoreg_e),
    .writesreg_e (bus.writesreg_e),
    .rd_m        (bus.rd_m),
    .writesreg_m (bus.writesreg_m),
    .rd_w        (bus.rd_w),
    .writesreg_w (bus.writesreg_w),
    .hazard      (hazard),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b)
  );

  // State, drain counter, halted flag and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      halted_q    <= (state_nxt == HALT);
      stall_cnt_q <= stall_cnt_q + 32'(sd);
    end
  end

  // Next state and stall/flush controls; redirect wins in RUN.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sf        = 1'b0;
    sd        = 1'b0;
    fd        = 1'b0;
    fe        = 1'b0;
    unique case (state)
      RUN: begin
        if (bus.redirect_e) begin
          fd = 1'b1;
          fe = 1'b1;
        end else begin
          if (hazard) begin
            sf = 1'b1;
            sd = 1'b1;
            fe = 1'b1;
          end
          if (bus.pause_d) begin
            state_nxt = DRAIN;
            cnt_nxt   = DRAIN_CYCLES;
          end
        end
      end
      DRAIN: begin
        sf      = 1'b1;
        sd      = 1'b1;
        fe      = 1'b1;
        cnt_nxt = cnt - 2'd1;
        if (cnt == 2'd1)
          state_nxt = HALT;
      end
      HALT: begin
        sf = 1'b1;
        sd = 1'b1;
        fe = 1'b1;
        if (bus.resume_i) begin
          state_nxt = RUN;
          fd        = 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign bus.stall_f   = sf;
  assign bus.stall_d   = sd;
  assign bus.flush_d   = fd;
  assign bus.flush_e   = fe;
  assign bus.fwd_a_e   = fwd_a;
  assign bus.fwd_b_e   = fwd_b;
  assign bus.halted    = halted_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports, one per line: name  direction  width  meaning.
  clk  in  1  single clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  rs1_d, rs2_d  in  5  decode-stage source registers
  use_rs1_d, use_rs2_d  in  1  decode instruction reads rs1/rs2
  pause_d  in  1  decoder pause (ECALL/EBREAK/FENCE class)
  rs1_e, rs2_e, rd_e  in  5  execute-stage registers
  memtoreg_e, writesreg_e  in  1  execute-stage load / regfile-write flags
  redirect_e  in  1  taken branch/jump resolved in execute
  rd_m, rd_w  in  5  memory/writeback destination registers
  writesreg_m, writesreg_w  in  1  memory/writeback regfile-write flags
  resume_i  in  1  one-cycle pulse releasing halt
  stall_f, stall_d  out  1  hold PC / IF-ID register
  flush_d, flush_e  out  1  bubble IF-ID / ID-EX register
  fwd_a_e, fwd_b_e  out  2  execute operand select: 00 regfile, 01 WB, 10 MEM
  halted  out  1  pipeline drained and stopped
  stall_cnt  out  32  cycles with stall_d asserted
REQ-002 SHALL have no parameters; DRAIN_CYCLES is the package constant 3.

Function
REQ-003 SHALL treat register x0 as never hazardous: every comparison requires the producer rd to be nonzero.
REQ-004 SHALL detect a load-use hazard when memtoreg_e & writesreg_e & rd_e matches (rs1_d & use_rs1_d) or (rs2_d & use_rs2_d).
REQ-005 On load-use, SHALL assert stall_f=stall_d=flush_e=1 in the same cycle (combinational), for exactly one cycle per hazard.
REQ-006 On redirect_e, SHALL assert flush_d=flush_e=1 and stall_f=stall_d=0; redirect outranks load-use and pause.
REQ-007 fwd_a_e SHALL be 10 when writesreg_m & rd_m==rs1_e, else 01 when writesreg_w & rd_w==rs1_e, else 00; MEM outranks WB. fwd_b_e is the same using rs2_e.
REQ-008 FSM states: RUN, DRAIN, HALT.
REQ-009 RUN->DRAIN SHALL occur when pause_d=1 and redirect_e=0; the drain counter loads DRAIN_CYCLES.
REQ-010 In DRAIN and HALT, SHALL assert stall_f=stall_d=flush_e=1.
REQ-011 In DRAIN, the counter SHALL decrement each cycle; at counter==1 the FSM SHALL go to HALT, so HALT is reached 3 cycles after entry.
REQ-012 halted SHALL be registered and equal 1 exactly while in HALT.
REQ-013 In HALT, resume_i=1 SHALL move the FSM to RUN and SHALL assert flush_d=1 that cycle, retiring the pause instruction.
REQ-014 resume_i SHALL be ignored in RUN and DRAIN.
REQ-015 stall_cnt SHALL increment when stall_d=1 and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-016 On rst_n=0, asynchronously: FSM=RUN, drain counter=0, halted=0, stall_cnt=0.
REQ-017 During reset, combinational outputs SHALL follow their RUN-state equations.
REQ-018 A reset asserted in DRAIN or HALT SHALL abandon the drain with no residual stall after release.

Configuration
REQ-019 Macro PIPE_CTRL_FORWARD_EN defined: forwarding SHALL follow REQ-007.
REQ-020 Macro PIPE_CTRL_FORWARD_EN undefined:
  - fwd_a_e and fwd_b_e SHALL be tied to 00.
  - stall_f=stall_d=flush_e=1 on any decode source match against a writing E or M stage (regfile is write-first for W).
  - REQ-004/REQ-005 SHALL be subsumed by this rule.

Structure
REQ-021 Package pipe_ctrl_pkg SHALL hold:
  - the state enum
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10
  - DRAIN_CYCLES
REQ-022 Register-compare and forward-select logic SHALL be the combinational sub-module hazard_fwd_unit; the FSM and counters stay in pipe_ctrl.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
  - Load-use: memtoreg_e=1, writesreg_e=1, rd_e=5, rs1_d=5, use_rs1_d=1 -> stall_f=stall_d=flush_e=1 one cycle, stall_cnt +1.
  - Forward priority: rd_m=rd_w=rs1_e=7, both writing -> fwd_a_e=10. With rd_m=0 -> fwd_a_e=01.
  - x0: rd_e=0 load, rs1_d=0 -> no stall.
  - Redirect with simultaneous load-use and pause_d -> flush_d=flush_e=1, stall_d=0, FSM stays RUN.
  - Pause: pause_d=1 -> halted=1 after 3 cycles. resume_i ignored in DRAIN. resume_i in HALT -> RUN with flush_d=1.
  - Reset mid-DRAIN -> halted=0, stall_cnt=0, no stall after release. With PIPE_CTRL_FORWARD_EN undefined, rd_m=rs2_d=3 -> stall, fwd=00.
